// File: rtl/arbiter_rr_ctrl.sv
// arbiter_rr_ctrl: registered round-robin arbiter with sticky grants.
// Two-state Moore controller (IDLE/BUSY) with a registered one-hot grant,
// binary owner ID and valid flag. The priority pointer always names the
// last winner, so the search starts one past it and wraps.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter that preempts
// an owner after HOLD_MAX grant cycles while others are waiting.
module arbiter_rr_ctrl #(
  parameter int N        = 3,
  parameter int W        = (N > 1) ? $clog2(N) : 1,
  parameter int HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         valid,
  output logic         timeout
);

  if (N < 2) begin : g_bad_n
    $error("arbiter_rr_ctrl: N must be >= 2");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("arbiter_rr_ctrl: HOLD_MAX must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state, state_n;
  logic [N-1:0] gnt_n, cand;
  logic [W-1:0] id_n, ptr, ptr_n, win;
  logic         found, own_req, new_grant, tmo_n, preempt;

  // Round-robin search over the candidates, starting one past the pointer.
  // While busy the owner is masked out so only a different requester can win.
  always_comb begin
    cand    = (state == BUSY) ? (req & ~gnt) : req;
    own_req = |(req & gnt);
    found   = 1'b0;
    win     = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = W'(idx);
      end
    end
  end

  // Next-state and next-output logic; defaults hold everything.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    id_n      = gnt_id;
    ptr_n     = ptr;
    new_grant = 1'b0;
    tmo_n     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n   = BUSY;
          gnt_n     = {{(N-1){1'b0}}, 1'b1} << win;
          id_n      = win;
          ptr_n     = win;
          new_grant = 1'b1;
        end
      end
      BUSY: begin
        if (!own_req) begin
          if (found) begin
            // Direct handoff, no idle gap.
            gnt_n     = {{(N-1){1'b0}}, 1'b1} << win;
            id_n      = win;
            ptr_n     = win;
            new_grant = 1'b1;
          end else begin
            // Release: ID and pointer keep the last owner.
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else if (preempt) begin
          gnt_n     = {{(N-1){1'b0}}, 1'b1} << win;
          id_n      = win;
          ptr_n     = win;
          new_grant = 1'b1;
          tmo_n     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; pointer resets to N-1 so requester 0 leads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      ptr     <= W'(N-1);
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_id  <= id_n;
      ptr     <= ptr_n;
      valid   <= |gnt_n;
      timeout <= tmo_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int             HW    = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]  HLAST = HW'(HOLD_MAX - 1);

  logic [HW-1:0] hcnt;

  // Preempt only a still-requesting owner that has used its full budget
  // while someone else is waiting.
  assign preempt = (state == BUSY) && own_req && found && (hcnt == HLAST);

  // Hold counter: cleared on each new grant, saturating count of busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              hcnt <= '0;
    else if (new_grant)                      hcnt <= '0;
    else if (state == BUSY && hcnt != HLAST) hcnt <= hcnt + 1'b1;
  end
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_rr_ctrl.sv
// Bench for arbiter_rr_ctrl (N=3, HOLD_MAX=4): directed steps with literal
// expectations plus randomized requests against a behavioural model.
module tb_arbiter_rr_ctrl;
  localparam int N        = 3;
  localparam int W        = 2;
  localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_id;
  logic         valid, timeout;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  arbiter_rr_ctrl #(.N(N), .W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the resource, how long it has held it,
  // and the last winner from which the next search begins.
  int           m_owner;
  int           m_last;
  int           m_ptr;
  int           m_cycles;
  bit           m_tmo;
  logic [N-1:0] m_req;

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_last = 0; m_ptr = N-1; m_cycles = 0; m_tmo = 0; m_req = '0;
    end else begin
      bit others, keeps;
      int w;
      m_req = req;
      m_tmo = 0;
      others = 0;
      for (int j = 0; j < N; j++) if (j != m_owner && req[j]) others = 1;
      keeps = (m_owner >= 0) && req[m_owner] &&
              !(TMO && m_cycles >= HOLD_MAX && others);
      if (keeps) m_cycles++;
      else begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (w < 0 && j != m_owner && req[j]) w = j;
        end
        if (w >= 0) begin
          m_tmo    = (m_owner >= 0) && req[m_owner];
          m_owner  = w; m_ptr = w; m_last = w; m_cycles = 1;
        end else m_owner = -1;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model and invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", 32'(gnt), 32'(m_gnt()));
      chk("gnt_id", 32'(gnt_id), 32'(m_last));
      chk("valid", 32'(valid), 32'(m_owner >= 0));
      chk("timeout", 32'(timeout), 32'(m_tmo));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("valid_or", 32'(valid), 32'(|gnt));
      chk("gnt_no_req", 32'(gnt & ~m_req), 32'd0);
    end
  end

  // Drive req at the falling edge, return 1 after the following rising edge.
  task automatic cyc(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_id"}, 32'(gnt_id), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #3;
    chk_reset("por");
    @(negedge clk); rst_n = 1'b1;

    // Start from reset: requester 0 first.
    cyc(3'b111);
    chk("start_gnt", 32'(gnt), 32'b001);
    chk("start_id", 32'(gnt_id), 32'd0);
    chk("start_valid", 32'(valid), 32'd1);
    chk("model_start", 32'(m_gnt()), 32'b001);

    // Rotation and wrap-around.
    cyc(3'b110); chk("rot1", 32'(gnt), 32'b010);
    cyc(3'b101); chk("rot2", 32'(gnt), 32'b100);
    chk("model_rot2", 32'(m_gnt()), 32'b100);
    cyc(3'b001); chk("rot_wrap", 32'(gnt), 32'b001);

    // Asynchronous reset while GNT=010.
    cyc(3'b010); chk("pre_rst", 32'(gnt), 32'b010);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    @(negedge clk); req = '0; rst_n = 1'b1;

    // Idle, then search resumes after the last owner.
    cyc(3'b100); chk("idle_pre", 32'(gnt), 32'b100);
    cyc(3'b000);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_valid", 32'(valid), 32'd0);
    chk("idle_id", 32'(gnt_id), 32'd2);
    cyc(3'b011); chk("idle_resume", 32'(gnt), 32'b001);

    // Hold timeout under contention.
    for (int i = 0; i < 3; i++) begin
      cyc(3'b011);
      chk("hold_gnt", 32'(gnt), 32'b001);
      chk("hold_tmo", 32'(timeout), 32'd0);
    end
    cyc(3'b011);
    chk("tmo_gnt", 32'(gnt), TMO ? 32'b010 : 32'b001);
    chk("tmo_pulse", 32'(timeout), 32'(TMO));
    chk("model_tmo", 32'(m_tmo), 32'(TMO));
    cyc(3'b011);
    chk("tmo_after_gnt", 32'(gnt), TMO ? 32'b010 : 32'b001);
    chk("tmo_after", 32'(timeout), 32'd0);

    // Lone owner keeps the grant indefinitely.
    for (int i = 0; i < 20; i++) begin
      cyc(3'b100);
      chk("lone_gnt", 32'(gnt), 32'b100);
      chk("lone_tmo", 32'(timeout), 32'd0);
    end

    // Randomized requests: held bits tend to stay, idle bits sometimes rise.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = req;
      for (int b = 0; b < N; b++)
        r[b] = r[b] ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
      if ($urandom_range(99) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("rand_rst");
        @(negedge clk); rst_n = 1'b1;
      end
      cyc(r);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
